float_adder_pipe: RTL
=====================

FLOAT_ADDER_PIPE -- requirements
Module: float_adder_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair a, b, sub presented.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 a  input  W  IEEE-754-style operand A.
REQ-009 b  input  W  IEEE-754-style operand B.
REQ-010 sub  input  1  1 = compute a-b; 0 = compute a+b.
REQ-011 out_valid  output  1  result held on Out.
REQ-012 out_ready  input  1  consumer takes Out this cycle.
REQ-013 Out  output  W  rounded result.
REQ-014 flags  output  4  {invalid, overflow, underflow, inexact} for Out.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Pipeline SHALL have 4 registered stages: S1 unpack/compare/swap, S2 align (right shift with guard, round, sticky), S3 add/subtract and leading-zero normalise, S4 round-to-nearest-even and pack.
REQ-017 Latency SHALL be exactly 4 cycles from input transfer to out_valid when out_ready is held 1; throughput 1 result/cycle.
REQ-018 Stall: in_ready = !out_valid || out_ready; all stages SHALL advance only when in_ready=1, otherwise hold contents (bubbles included).
REQ-019 Out and flags SHALL remain stable while out_valid && !out_ready.
REQ-020 sub=1 SHALL invert B's sign before S1; all rules below apply to the effective operation.
REQ-021 Alignment shift >= MAN_W+3 SHALL collapse the smaller operand into sticky only.
REQ-022 Subnormal inputs (exp=0) SHALL be treated as signed zero; results below the minimum normal SHALL flush to signed zero with underflow=1 and inexact=1.
REQ-023 Exact cancellation (x + -x) SHALL give +0; (-0)+(-0) SHALL give -0.
REQ-024 Any NaN input, or inf + -inf effective, SHALL give canonical quiet NaN (sign 0, exp all-ones, fraction MSB 1, rest 0), invalid=1.
REQ-025 inf + finite or same-sign inf SHALL give that inf, flags all 0.
REQ-026 Exponent overflow after rounding SHALL give signed inf with overflow=1, inexact=1.
REQ-027 inexact SHALL be 1 whenever guard|round|sticky != 0 at S4.

Reset
REQ-028 While rst=1 at a clock edge, all stage valid bits, out_valid, Out and flags SHALL clear to 0; in-flight operations SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Shared package float_pkg SHALL hold EXP_W/MAN_W defaults, bias, derived widths, canonical NaN and inf constants, and the stage-record typedefs.
REQ-031 Leading-zero count SHALL be a separate sub-module float_lzc, parametrised by input width, used in S3.
REQ-032 Implementation SHALL be 120-400 lines, no vendor primitives.

Verification (EXP_W=8, MAN_W=23)
REQ-033 a=BF800000, b=C0600000, sub=0 -> Out=C0900000, flags=0, out_valid exactly 4 cycles after transfer.
REQ-034 a=3F800000, b=40400000 back-to-back with a=3F800000, b=3F800000, sub=1 -> Out=40800000 then 00000000 on consecutive cycles.
REQ-035 a=3F800000, b=33800000 -> Out=3F800000, inexact=1 (tie to even); a=7F7FFFFF, b=7F7FFFFF -> 7F800000, overflow=1, inexact=1.
REQ-036 a=7F800000, b=FF800000 -> Out=7FC00000, invalid=1; a=7FC00001, b=3F800000 -> 7FC00000, invalid=1.
REQ-037 Stream 8 operand pairs with out_ready toggling pseudo-randomly -> no result lost, duplicated or reordered; Out stable while stalled.
REQ-038 Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale results emerge, next op returns correctly after 4 cycles.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the pipelined floating-point adder: format widths,
// special-value encodings and the records carried between pipeline stages.
package float_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int FP_W      = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int EXP_MAX   = 2 * BIAS + 1;
    localparam int SIG_W     = DEF_MAN_W + 1;
    localparam int ALN_W     = SIG_W + 3;
    localparam int SUM_W     = ALN_W + 1;
    localparam int LZC_W     = $clog2(SUM_W + 1);
    localparam int XEXP_W    = DEF_EXP_W + 2;

    localparam logic [DEF_EXP_W-1:0] EXP_ONES       = '1;
    localparam logic [DEF_EXP_W-1:0] COLLAPSE_SHIFT = DEF_EXP_W'(DEF_MAN_W + 3);

    localparam logic [FP_W-1:0] QNAN    = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};
    localparam logic [FP_W-1:0] POS_INF = {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};
    localparam logic [FP_W-1:0] NEG_INF = {1'b1, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

    // A result already decided in S1 (NaN, infinity, signed zero) rides along here
    typedef struct packed {
        logic            hit;
        logic [FP_W-1:0] value;
        flags_t          flags;
    } spec_t;

    typedef struct packed {
        logic                 valid;
        spec_t                spec;
        logic                 sign;
        logic                 eff_sub;
        logic [DEF_EXP_W-1:0] exp_l;
        logic [DEF_EXP_W-1:0] diff;
        logic [SIG_W-1:0]     sig_l;
        logic [SIG_W-1:0]     sig_s;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        spec_t                spec;
        logic                 sign;
        logic                 eff_sub;
        logic [DEF_EXP_W-1:0] exp_l;
        logic [ALN_W-1:0]     aln_l;
        logic [ALN_W-1:0]     aln_s;
    } s2_t;

    typedef struct packed {
        logic              valid;
        spec_t             spec;
        logic              sign;
        logic              zero;
        logic [XEXP_W-1:0] exp_n;
        logic [SIG_W-1:0]  man;
        logic              guard;
        logic              rnd;
        logic              sticky;
    } s3_t;

endpackage

// File: rtl/float_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module float_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the highest set bit win without a found flag
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/float_adder_pipe.sv
// Four-stage IEEE-754-style adder/subtractor with valid/ready handshake,
// round-to-nearest-even, flush-to-zero and a single global stall.
module float_adder_pipe
    import float_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     Out,
    output logic [3:0]               flags
);

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic [FP_W-1:0] out_d;
    flags_t          flags_d;

    assign in_ready = !out_valid || out_ready;

    logic                           sa, sb, swap;
    logic                           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [DEF_EXP_W-1:0]           ea, eb;
    logic [DEF_MAN_W-1:0]           ma, mb;
    logic [DEF_EXP_W+DEF_MAN_W-1:0] mag_a, mag_b;
    logic [SIG_W-1:0]               sig_a, sig_b;

    assign sa     = a[FP_W-1];
    assign sb     = b[FP_W-1] ^ sub;
    assign ea     = a[FP_W-2 -: DEF_EXP_W];
    assign eb     = b[FP_W-2 -: DEF_EXP_W];
    assign ma     = a[DEF_MAN_W-1:0];
    assign mb     = b[DEF_MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);
    assign mag_a  = a_zero ? '0 : {ea, ma};
    assign mag_b  = b_zero ? '0 : {eb, mb};
    assign sig_a  = a_zero ? '0 : {1'b1, ma};
    assign sig_b  = b_zero ? '0 : {1'b1, mb};
    assign swap   = (mag_b > mag_a);

    // S1: subnormals are already folded to zero above, so the larger magnitude
    // always carries the result sign and subtraction never goes negative
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = in_valid;
        s1_d.sign    = swap ? sb : sa;
        s1_d.eff_sub = sa ^ sb;
        s1_d.exp_l   = swap ? eb : ea;
        s1_d.diff    = swap ? (eb - ea) : (ea - eb);
        s1_d.sig_l   = swap ? sig_b : sig_a;
        s1_d.sig_s   = swap ? sig_a : sig_b;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            s1_d.spec.hit           = 1'b1;
            s1_d.spec.value         = QNAN;
            s1_d.spec.flags.invalid = 1'b1;
        end else if (a_inf) begin
            s1_d.spec.hit   = 1'b1;
            s1_d.spec.value = sa ? NEG_INF : POS_INF;
        end else if (b_inf) begin
            s1_d.spec.hit   = 1'b1;
            s1_d.spec.value = sb ? NEG_INF : POS_INF;
        end else if (a_zero && b_zero) begin
            s1_d.spec.hit   = 1'b1;
            s1_d.spec.value = {sa & sb, {(FP_W-1){1'b0}}};
        end
    end

    logic [ALN_W-1:0] aln_s_raw, aln_mask;

    assign aln_s_raw = {s1_q.sig_s, 3'b000};
    assign aln_mask  = (ALN_W'(1) << s1_q.diff) - ALN_W'(1);

    // S2: bits shifted out below the sticky position are ORed back into it
    always_comb begin
        s2_d         = '0;
        s2_d.valid   = s1_q.valid;
        s2_d.spec    = s1_q.spec;
        s2_d.sign    = s1_q.sign;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.exp_l   = s1_q.exp_l;
        s2_d.aln_l   = {s1_q.sig_l, 3'b000};
        if (s1_q.diff >= COLLAPSE_SHIFT) begin
            s2_d.aln_s = {{(ALN_W-1){1'b0}}, |s1_q.sig_s};
        end else begin
            s2_d.aln_s = (aln_s_raw >> s1_q.diff)
                       | {{(ALN_W-1){1'b0}}, |(aln_s_raw & aln_mask)};
        end
    end

    logic [SUM_W-1:0] sum, norm;
    logic [LZC_W-1:0] lz;

    assign sum  = s2_q.eff_sub ? ({1'b0, s2_q.aln_l} - {1'b0, s2_q.aln_s})
                               : ({1'b0, s2_q.aln_l} + {1'b0, s2_q.aln_s});
    assign norm = sum << lz;

    float_lzc #(
        .WIDTH (SUM_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .value (sum),
        .count (lz)
    );

    // S3: the top sum bit is the carry slot, so a zero leading count means +1 on the exponent
    always_comb begin
        s3_d        = '0;
        s3_d.valid  = s2_q.valid;
        s3_d.spec   = s2_q.spec;
        s3_d.sign   = s2_q.sign;
        s3_d.zero   = (sum == '0);
        s3_d.exp_n  = XEXP_W'(s2_q.exp_l) + XEXP_W'(1) - XEXP_W'(lz);
        s3_d.man    = norm[SUM_W-1 -: SIG_W];
        s3_d.guard  = norm[SUM_W-SIG_W-1];
        s3_d.rnd    = norm[SUM_W-SIG_W-2];
        s3_d.sticky = |norm[SUM_W-SIG_W-3:0];
    end

    logic              inc;
    logic [SIG_W:0]    rounded;
    logic [XEXP_W-1:0] exp_r;
    logic [SIG_W-1:0]  man_r;

    assign inc     = s3_q.guard & (s3_q.rnd | s3_q.sticky | s3_q.man[0]);
    assign rounded = {1'b0, s3_q.man} + {{SIG_W{1'b0}}, inc};
    assign exp_r   = s3_q.exp_n + {{(XEXP_W-1){1'b0}}, rounded[SIG_W]};
    assign man_r   = rounded[SIG_W] ? rounded[SIG_W:1] : rounded[SIG_W-1:0];

    // S4: exact cancellation lands on +0; tiny results flush before rounding is considered
    always_comb begin
        out_d   = '0;
        flags_d = '0;
        if (s3_q.spec.hit) begin
            out_d   = s3_q.spec.value;
            flags_d = s3_q.spec.flags;
        end else if (s3_q.zero) begin
            out_d = '0;
        end else if ($signed(s3_q.exp_n) <= 0) begin
            out_d             = {s3_q.sign, {(FP_W-1){1'b0}}};
            flags_d.underflow = 1'b1;
            flags_d.inexact   = 1'b1;
        end else if ($signed(exp_r) >= EXP_MAX) begin
            out_d            = s3_q.sign ? NEG_INF : POS_INF;
            flags_d.overflow = 1'b1;
            flags_d.inexact  = 1'b1;
        end else begin
            out_d           = {s3_q.sign, exp_r[DEF_EXP_W-1:0], man_r[DEF_MAN_W-1:0]};
            flags_d.inexact = s3_q.guard | s3_q.rnd | s3_q.sticky;
        end
    end

    // The whole pipe, bubbles included, moves only when the output slot can take a result
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            out_valid <= 1'b0;
            Out       <= '0;
            flags     <= '0;
        end else if (in_ready) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            out_valid <= s3_q.valid;
            Out       <= out_d;
            flags     <= flags_d;
        end
    end

endmodule
